// File: rtl/mem_pkg.sv
// Shared types and default geometry for the main memory responder and its arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    LOAD  = 1'b0,
    WRITE = 1'b1
  } op_t;

  localparam int DEF_CORES      = 32;
  localparam int DEF_BITS       = 16;
  localparam int DEF_PORTS      = 2;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int REQ_ADDR_W     = 16;

  // Index width that stays legal for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the port after the last accepted grant.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int PORTS = DEF_PORTS
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [PORTS-1:0]            req,
  input  logic                        accept,
  output logic [PORTS-1:0]            grant,
  output logic [idx_width(PORTS)-1:0] grant_idx
);

  localparam int IW = idx_width(PORTS);

  logic [IW-1:0] last;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last) + i) % PORTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Resetting to the highest port makes port 0 the first candidate.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last <= IW'(PORTS - 1);
    end else if (accept) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Single-bank word memory shared by several requester ports, one access at a time.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int CORES      = DEF_CORES,
  parameter int BITS       = DEF_BITS,
  parameter int PORTS      = DEF_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [PORTS-1:0]              load_ctrl,
  input  logic [PORTS-1:0]              write_ctrl,
  input  logic [PORTS*REQ_ADDR_W-1:0]   addr,
  input  logic [PORTS*CORES*BITS-1:0]   write_data,
  output logic [PORTS-1:0]              ready,
  output logic [CORES*BITS-1:0]         load_data,
  output logic [PORTS-1:0]              load_valid,
  output logic                          addr_err,
  output logic                          proto_err,
  output state_t                        fsm_state
);

  localparam int          W       = CORES * BITS;
  localparam int          IW      = idx_width(PORTS);
  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  // Handshake: a port holds load_ctrl/write_ctrl (and addr/write_data) steady
  // until it sees its ready bit high at a rising edge; that edge is the accept.
  // load_valid then qualifies load_data for exactly one cycle.

  state_t                  state, next;
  logic [PORTS-1:0]        req, grant;
  logic [IW-1:0]           gidx, lat_port;
  logic                    accept, in_range, mem_we;
  op_t                     lat_op;
  logic [REQ_ADDR_W-1:0]   lat_addr;
  logic [W-1:0]            lat_data;
  logic [ADDR_WIDTH-1:0]   mem_idx;
  logic [W-1:0]            storage [DEPTH];

  assign req       = load_ctrl | write_ctrl;
  assign accept    = reset_n && (state == IDLE) && (|req);
  assign in_range  = 32'(lat_addr) < DEPTH_L;
  assign mem_idx   = lat_addr[ADDR_WIDTH-1:0];
  assign mem_we    = reset_n && (state == EXEC) && (lat_op == WRITE) && in_range;
  assign fsm_state = state;

  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    next       = state;
    ready      = '0;
    load_valid = '0;
    addr_err   = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ready     = grant;
          proto_err = load_ctrl[gidx] & write_ctrl[gidx];
          next      = EXEC;
        end
      end
      EXEC: begin
        addr_err = reset_n && !in_range;
        next     = (lat_op == LOAD) ? RESP : IDLE;
      end
      RESP: begin
        load_valid[lat_port] = reset_n;
        next                 = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // A port raising both controls is served as a write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_port  <= '0;
      lat_op    <= LOAD;
      lat_addr  <= '0;
      lat_data  <= '0;
      load_data <= '0;
    end else begin
      state <= next;
      if (accept) begin
        lat_port <= gidx;
        lat_op   <= write_ctrl[gidx] ? WRITE : LOAD;
        lat_addr <= addr[gidx*REQ_ADDR_W +: REQ_ADDR_W];
        lat_data <= write_data[gidx*W +: W];
      end
      if (state == EXEC && lat_op == LOAD) begin
        load_data <= in_range ? storage[mem_idx] : '0;
      end
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      storage[mem_idx] <= lat_data;
    end
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter CORES, default 32, number of lanes per memory word.
REQ-002 SHALL have parameter BITS, default 16, bits per lane.
REQ-003 SHALL have parameter PORTS, default 2, number of processing-block requester ports.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, so the storage depth is 2**ADDR_WIDTH words of CORES*BITS bits.
REQ-005 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port load_ctrl  input  PORTS  per-port load request, held high until accepted.
REQ-008 SHALL have port write_ctrl  input  PORTS  per-port write request, held high until accepted.
REQ-009 SHALL have port addr  input  PORTS*16  per-port 16-bit word address; port p occupies bits [p*16 +: 16].
REQ-010 SHALL have port write_data  input  PORTS*CORES*BITS  per-port write word.
REQ-011 SHALL have port ready  output  PORTS  one-cycle accept pulse to the granted port.
REQ-012 SHALL have port load_data  output  CORES*BITS  shared load response word.
REQ-013 SHALL have port load_valid  output  PORTS  one-cycle pulse qualifying load_data for the addressed port.
REQ-014 SHALL have port addr_err  output  1  one-cycle pulse on an out-of-range access.
REQ-015 SHALL have port proto_err  output  1  one-cycle pulse when a port asserts load_ctrl and write_ctrl together.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC and RESP, handling one request at a time.
REQ-017 In IDLE with any request pending, SHALL grant round-robin starting at the port after the last granted one, pulse ready for that port, latch port/op/addr/data and go to EXEC.
REQ-018 In IDLE with no request pending, SHALL remain in IDLE with ready all zero.
REQ-019 In EXEC for a write, SHALL store the latched data at the latched address and return to IDLE.
REQ-020 In EXEC for a load, SHALL register the word at the latched address into load_data and go to RESP.
REQ-021 In RESP, SHALL pulse load_valid for the latched port for exactly one cycle and return to IDLE.
REQ-022 Load latency SHALL be: ready in cycle T, load_valid in cycle T+2; write occupancy is 2 cycles, load occupancy is 3 cycles.
REQ-023 load_data SHALL hold its value until the next load's EXEC cycle.
REQ-024 Accesses SHALL complete in grant order, so a load granted after a write to the same address returns the new data.
REQ-025 A port asserting both load_ctrl and write_ctrl SHALL be treated as a write, with proto_err pulsed in the grant cycle.
REQ-026 An address >= 2**ADDR_WIDTH SHALL pulse addr_err in EXEC; a write to it is dropped, and a load from it returns zero with load_valid still pulsed.
REQ-027 The round-robin pointer SHALL advance only on a grant.
REQ-028 A request deasserted before grant SHALL be ignored.

Reset
REQ-029 While reset_n is low at a clock edge, SHALL force IDLE, with ready, load_valid, addr_err, proto_err and load_data all zero.
REQ-030 While reset_n is low at a clock edge, SHALL set the round-robin pointer so port 0 has priority next.
REQ-031 Reset SHALL take priority over EXEC: a write in flight is not performed, and a load in flight produces no load_valid.
REQ-032 Storage contents SHALL NOT be reset.

Structure
REQ-033 Package mem_pkg SHALL hold the FSM state type, the op encoding (LOAD, WRITE) and the default word-width constants.
REQ-034 The arbiter SHALL be a separate sub-module, rr_arbiter (PORTS requests, one-hot grant, pointer update on accept).

Verification
REQ-035 Reset then write port0 addr 5 = 0xA5A5 in every lane, then load port0 addr 5 -> load_valid[0] two cycles after ready with data 0xA5A5 in every lane.
REQ-036 Ports 0 and 1 both request continuously after reset -> grants alternate 0,1,0,1 and no port is starved.
REQ-037 Port0 writes addr 3 = 0x1111 and port1 loads addr 3 in the same IDLE cycle -> port0 granted first, port1 receives 0x1111.
REQ-038 Load from addr 0x0400 with ADDR_WIDTH=10 -> addr_err pulses once, load_data = 0, load_valid pulses.
REQ-039 Port1 asserts load_ctrl and write_ctrl together with addr 7 = 0x2222 -> proto_err pulses, and a later load of addr 7 returns 0x2222.
REQ-040 reset_n low during EXEC of a write to addr 9 -> addr 9 keeps its old value and the FSM is in IDLE after reset.
